// File: rtl/temple_run_pkg.sv
// Shared lane codes, move encodings, player FSM states and lane ranking.
// The game generator imports the same package.
package temple_run_pkg;

    localparam int unsigned CODE_W = 2;
    localparam int unsigned LANE_W = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RANK_W = 2;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t OBST  = 2'b00;
    localparam code_t CLEAR = 2'b01;
    localparam code_t COIN  = 2'b10;

    localparam logic [LANE_W-1:0] MV_RIGHT  = 3'b100;
    localparam logic [LANE_W-1:0] MV_CENTRE = 3'b010;
    localparam logic [LANE_W-1:0] MV_LEFT   = 3'b001;
    localparam logic [LANE_W-1:0] MV_NONE   = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_ISSUE,
        ST_OVER
    } state_t;

    typedef struct packed {
        code_t right;
        code_t centre;
        code_t left;
    } row_t;

    // Coin beats clear beats obstacle; the reserved code ranks as an obstacle.
    function automatic logic [RANK_W-1:0] code_rank(input code_t c);
        case (c)
            COIN:    return RANK_W'(2);
            CLEAR:   return RANK_W'(1);
            default: return RANK_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/temple_run_lane_pick.sv
// Combinational lane chooser: best-ranked lane reachable from the current lane.
// Ties resolve current lane first, then centre, right, left.
module temple_run_lane_pick
    import temple_run_pkg::*;
(
    input  logic [LANE_W-1:0] lane,
    input  row_t              row,
    output logic [LANE_W-1:0] pick_lane_c,
    output code_t             pick_code_c
);

    code_t             cur_code;
    logic [RANK_W-1:0] best_rank;

    always_comb begin
        case (lane)
            MV_RIGHT: cur_code = row.right;
            MV_LEFT:  cur_code = row.left;
            default:  cur_code = row.centre;
        endcase

        pick_lane_c = lane;
        pick_code_c = cur_code;
        best_rank   = code_rank(cur_code);

        // Only strictly better lanes displace an earlier candidate; centre is always reachable.
        if (code_rank(row.centre) > best_rank) begin
            pick_lane_c = MV_CENTRE;
            pick_code_c = row.centre;
            best_rank   = code_rank(row.centre);
        end
        if (lane != MV_LEFT && code_rank(row.right) > best_rank) begin
            pick_lane_c = MV_RIGHT;
            pick_code_c = row.right;
            best_rank   = code_rank(row.right);
        end
        if (lane != MV_RIGHT && code_rank(row.left) > best_rank) begin
            pick_lane_c = MV_LEFT;
            pick_code_c = row.left;
            best_rank   = code_rank(row.left);
        end
    end

endmodule

// File: rtl/temple_run_player.sv
// Autonomous temple-run player: takes each row, issues a one-hot move over
// valid/ready and keeps coin, hit and lives bookkeeping with sticky game-over.
module temple_run_player
    import temple_run_pkg::*;
#(
    parameter int unsigned LIVES  = 3,
    parameter int unsigned COIN_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CODE_W-1:0]   path_right,
    input  logic [CODE_W-1:0]   path_centre,
    input  logic [CODE_W-1:0]   path_left,
    input  logic                row_valid,
    output logic [LANE_W-1:0]   move,
    output logic                move_valid,
    input  logic                move_ready,
    output logic [LANE_W-1:0]   lane,
    output logic [COIN_W-1:0]   coins,
    output logic [CNT_W-1:0]    hits,
    output logic [CNT_W-1:0]    lives,
    output logic                game_over,
    output logic                overrun
);

    state_t              state_q, state_d;
    row_t                row_q, row_d;
    logic [LANE_W-1:0]   move_q, move_d;
    logic                move_valid_q, move_valid_d;
    code_t               move_code_q, move_code_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [COIN_W-1:0]   coins_q, coins_d;
    logic [CNT_W-1:0]    hits_q, hits_d;
    logic [CNT_W-1:0]    lives_q, lives_d;
    logic                game_over_q, game_over_d;
    logic                overrun_q, overrun_d;

    logic [LANE_W-1:0]   pick_lane_c;
    code_t               pick_code_c;
    logic                accept;
    row_t                in_row;

    assign in_row = '{right: path_right, centre: path_centre, left: path_left};
    assign accept = move_valid_q && move_ready;

    temple_run_lane_pick u_lane_pick (
        .lane        (lane_q),
        .row         (row_q),
        .pick_lane_c (pick_lane_c),
        .pick_code_c (pick_code_c)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            move_q       <= MV_NONE;
            move_valid_q <= 1'b0;
            move_code_q  <= OBST;
            lane_q       <= MV_CENTRE;
            coins_q      <= '0;
            hits_q       <= '0;
            lives_q      <= CNT_W'(LIVES);
            game_over_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            move_q       <= move_d;
            move_valid_q <= move_valid_d;
            move_code_q  <= move_code_d;
            lane_q       <= lane_d;
            coins_q      <= coins_d;
            hits_q       <= hits_d;
            lives_q      <= lives_d;
            game_over_q  <= game_over_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state, handshake and scoring.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        move_d       = move_q;
        move_valid_d = move_valid_q;
        move_code_d  = move_code_q;
        lane_d       = lane_q;
        coins_d      = coins_q;
        hits_d       = hits_q;
        lives_d      = lives_q;
        game_over_d  = game_over_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (row_valid) begin
                    row_d   = in_row;
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                move_d       = pick_lane_c;
                move_code_d  = pick_code_c;
                move_valid_d = 1'b1;
                state_d      = ST_ISSUE;
                if (row_valid) begin
                    overrun_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    lane_d       = move_q;
                    move_d       = MV_NONE;
                    move_valid_d = 1'b0;
                    if (move_code_q == COIN) begin
                        if (coins_q != '1) begin
                            coins_d = coins_q + COIN_W'(1);
                        end
                    end else if (move_code_q != CLEAR) begin
                        if (hits_q != '1) begin
                            hits_d = hits_q + CNT_W'(1);
                        end
                        lives_d = lives_q - CNT_W'(1);
                    end
                    if (lives_d == '0) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                    end else if (row_valid) begin
                        row_d   = in_row;
                        state_d = ST_DECIDE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (row_valid) begin
                    overrun_d = 1'b1;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign move       = move_q;
    assign move_valid = move_valid_q;
    assign lane       = lane_q;
    assign coins      = coins_q;
    assign hits       = hits_q;
    assign lives      = lives_q;
    assign game_over  = game_over_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_temple_run_player.sv
// Self-checking bench for temple_run_player: directed scenarios plus randomized
// rows checked against a lane-index reference model.
module tb_temple_run_player;

    localparam int unsigned T_LIVES  = 3;
    localparam int unsigned T_COIN_W = 2;
    localparam int          COIN_MAX = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          path_right, path_centre, path_left;
    logic                row_valid;
    logic [2:0]          move;
    logic                move_valid;
    logic                move_ready;
    logic [2:0]          lane;
    logic [T_COIN_W-1:0] coins;
    logic [3:0]          hits;
    logic [3:0]          lives;
    logic                game_over;
    logic                overrun;

    int pass_cnt = 0;
    int total    = 0;

    // Reference model state: lane index 0 = right, 1 = centre, 2 = left.
    int m_lane, m_coins, m_hits, m_lives;

    temple_run_player #(.LIVES(T_LIVES), .COIN_W(T_COIN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .path_right  (path_right),
        .path_centre (path_centre),
        .path_left   (path_left),
        .row_valid   (row_valid),
        .move        (move),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .lane        (lane),
        .coins       (coins),
        .hits        (hits),
        .lives       (lives),
        .game_over   (game_over),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        row_valid = 1'b0;
        move_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    function automatic logic [2:0] hot(input int idx);
        logic [2:0] base;
        base = 3'b100;
        return base >> idx;
    endfunction

    function automatic int rank(input logic [1:0] c);
        if (c == 2'b10) return 2;
        if (c == 2'b01) return 1;
        return 0;
    endfunction

    function automatic int model_pick(input int cur, input logic [1:0] r, input logic [1:0] c, input logic [1:0] l);
        logic [1:0] cd [3];
        int order [4];
        int best;
        int d;
        cd[0] = r; cd[1] = c; cd[2] = l;
        order = '{cur, 1, 0, 2};
        best = cur;
        for (int k = 0; k < 4; k++) begin
            d = order[k] - cur;
            if (d < 0) d = -d;
            if (d <= 1 && rank(cd[order[k]]) > rank(cd[best])) best = order[k];
        end
        return best;
    endfunction

    task automatic model_reset();
        m_lane = 1; m_coins = 0; m_hits = 0; m_lives = T_LIVES;
    endtask

    task automatic model_score(input int idx, input logic [1:0] r, input logic [1:0] c, input logic [1:0] l);
        logic [1:0] cd [3];
        cd[0] = r; cd[1] = c; cd[2] = l;
        m_lane = idx;
        if (cd[idx] == 2'b10) begin
            if (m_coins < COIN_MAX) m_coins++;
        end else if (cd[idx] != 2'b01) begin
            if (m_hits < 15) m_hits++;
            m_lives--;
        end
    endtask

    // Drives one row, waits (bounded) for move_valid, stalls, then accepts.
    task automatic send_row(input logic [1:0] r, input logic [1:0] c, input logic [1:0] l,
                            input int stall, output logic [2:0] mv, output bit ok, output int lat);
        path_right = r; path_centre = c; path_left = l;
        row_valid = 1'b1;
        move_ready = 1'b0;
        cycle();
        row_valid = 1'b0;
        ok = 1'b0; mv = 3'b000; lat = -1;
        for (int i = 0; i < 4 && !ok; i++) begin
            cycle();
            if (move_valid === 1'b1) begin
                ok = 1'b1; mv = move; lat = i + 2;
            end
        end
        if (ok) begin
            repeat (stall) cycle();
            move_ready = 1'b1;
            cycle();
            move_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        total++; if (move !== 3'b000) $display("FAIL reset_move got=%b exp=000", move); else pass_cnt++;
        total++; if (move_valid !== 1'b0) $display("FAIL reset_move_valid got=%b exp=0", move_valid); else pass_cnt++;
        total++; if (lane !== 3'b010) $display("FAIL reset_lane got=%b exp=010", lane); else pass_cnt++;
        total++; if (coins !== '0) $display("FAIL reset_coins got=%0d exp=0", coins); else pass_cnt++;
        total++; if (hits !== 4'd0) $display("FAIL reset_hits got=%0d exp=0", hits); else pass_cnt++;
        total++; if (lives !== 4'(T_LIVES)) $display("FAIL reset_lives got=%0d exp=%0d", lives, T_LIVES); else pass_cnt++;
        total++; if (game_over !== 1'b0) $display("FAIL reset_game_over got=%b exp=0", game_over); else pass_cnt++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_first_row();
        logic [2:0] mv; bit ok; int lat;
        do_reset();
        send_row(2'b01, 2'b10, 2'b00, 0, mv, ok, lat);
        total++; if (lat !== 2) $display("FAIL first_latency got=%0d exp=2", lat); else pass_cnt++;
        total++; if (mv !== 3'b010) $display("FAIL first_move got=%b exp=010", mv); else pass_cnt++;
        total++; if (coins !== 2'd1) $display("FAIL first_coins got=%0d exp=1", coins); else pass_cnt++;
        total++; if (lane !== 3'b010) $display("FAIL first_lane got=%b exp=010", lane); else pass_cnt++;
        total++; if (move_valid !== 1'b0) $display("FAIL first_valid_drop got=%b exp=0", move_valid); else pass_cnt++;
    endtask

    task automatic test_adjacency();
        logic [2:0] mv; bit ok; int lat;
        do_reset();
        send_row(2'b10, 2'b00, 2'b00, 0, mv, ok, lat);
        total++; if (lane !== 3'b100) $display("FAIL adj_to_right got=%b exp=100", lane); else pass_cnt++;
        send_row(2'b00, 2'b01, 2'b10, 1, mv, ok, lat);
        total++; if (mv !== 3'b010) $display("FAIL adj_left_unreachable got=%b exp=010", mv); else pass_cnt++;
        total++; if (hits !== 4'd0) $display("FAIL adj_no_hit got=%0d exp=0", hits); else pass_cnt++;
        send_row(2'b00, 2'b00, 2'b10, 0, mv, ok, lat);
        total++; if (mv !== 3'b001) $display("FAIL adj_to_left got=%b exp=001", mv); else pass_cnt++;
        total++; if (coins !== 2'd2) $display("FAIL adj_coins got=%0d exp=2", coins); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [2:0] mv; bit ok; int lat; bit stable;
        do_reset();
        path_right = 2'b10; path_centre = 2'b01; path_left = 2'b01;
        row_valid = 1'b1;
        cycle();
        row_valid = 1'b0;
        cycle();
        mv = move;
        total++; if (move_valid !== 1'b1 || mv !== 3'b100) $display("FAIL bp_issue got=%b/%b exp=1/100", move_valid, mv); else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                path_right = 2'b00; path_centre = 2'b10; path_left = 2'b10;
                row_valid = 1'b1;
            end
            cycle();
            row_valid = 1'b0;
            if (move !== mv || move_valid !== 1'b1) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) $display("FAIL bp_stable got=%b exp=%b", move, mv); else pass_cnt++;
        total++; if (overrun !== 1'b1) $display("FAIL bp_overrun got=%b exp=1", overrun); else pass_cnt++;
        move_ready = 1'b1;
        cycle();
        move_ready = 1'b0;
        total++; if (move_valid !== 1'b0 || lane !== 3'b100) $display("FAIL bp_accept got=%b/%b exp=0/100", move_valid, lane); else pass_cnt++;
        total++; if (coins !== 2'd1) $display("FAIL bp_coins got=%0d exp=1", coins); else pass_cnt++;
        send_row(2'b01, 2'b10, 2'b10, 0, mv, ok, lat);
        total++; if (mv !== 3'b010 || overrun !== 1'b1) $display("FAIL bp_after got=%b/%b exp=010/1", mv, overrun); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        move_ready = 1'b1;
        path_right = 2'b10; path_centre = 2'b01; path_left = 2'b00;
        row_valid = 1'b1;
        cycle();
        row_valid = 1'b0;
        cycle();
        total++; if (move_valid !== 1'b1 || move !== 3'b100) $display("FAIL b2b_first got=%b/%b exp=1/100", move_valid, move); else pass_cnt++;
        path_right = 2'b01; path_centre = 2'b10; path_left = 2'b10;
        row_valid = 1'b1;
        cycle();
        row_valid = 1'b0;
        total++; if (move_valid !== 1'b0 || lane !== 3'b100) $display("FAIL b2b_accept got=%b/%b exp=0/100", move_valid, lane); else pass_cnt++;
        cycle();
        total++; if (move_valid !== 1'b1 || move !== 3'b010) $display("FAIL b2b_second got=%b/%b exp=1/010", move_valid, move); else pass_cnt++;
        cycle();
        move_ready = 1'b0;
        total++; if (lane !== 3'b010 || coins !== 2'd2) $display("FAIL b2b_score got=%b/%0d exp=010/2", lane, coins); else pass_cnt++;
        total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got=%b exp=0", overrun); else pass_cnt++;
    endtask

    task automatic test_lives();
        logic [2:0] mv; bit ok; int lat;
        do_reset();
        send_row(2'b00, 2'b11, 2'b00, 0, mv, ok, lat);
        total++; if (lives !== 4'd2 || game_over !== 1'b0) $display("FAIL lives_first got=%0d/%b exp=2/0", lives, game_over); else pass_cnt++;
        send_row(2'b11, 2'b00, 2'b11, 0, mv, ok, lat);
        send_row(2'b00, 2'b00, 2'b00, 0, mv, ok, lat);
        total++; if (hits !== 4'd3) $display("FAIL lives_hits got=%0d exp=3", hits); else pass_cnt++;
        total++; if (lives !== 4'd0) $display("FAIL lives_zero got=%0d exp=0", lives); else pass_cnt++;
        total++; if (game_over !== 1'b1) $display("FAIL lives_game_over got=%b exp=1", game_over); else pass_cnt++;
        send_row(2'b10, 2'b10, 2'b10, 0, mv, ok, lat);
        total++; if (ok !== 1'b0) $display("FAIL over_no_move got=%b exp=0", ok); else pass_cnt++;
        total++; if (overrun !== 1'b0 || game_over !== 1'b1) $display("FAIL over_flags got=%b/%b exp=0/1", overrun, game_over); else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [2:0] mv; bit ok; int lat;
        do_reset();
        for (int i = 0; i < 5; i++) send_row(2'b01, 2'b10, 2'b01, 0, mv, ok, lat);
        total++; if (coins !== 2'd3) $display("FAIL coin_sat got=%0d exp=3", coins); else pass_cnt++;
        total++; if (lives !== 4'(T_LIVES)) $display("FAIL coin_sat_lives got=%0d exp=%0d", lives, T_LIVES); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [2:0] mv; bit ok; int lat;
        do_reset();
        send_row(2'b00, 2'b00, 2'b01, 0, mv, ok, lat);
        path_right = 2'b10; path_centre = 2'b00; path_left = 2'b00;
        row_valid = 1'b1;
        cycle();
        row_valid = 1'b0;
        cycle();
        total++; if (move_valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", move_valid); else pass_cnt++;
        rst = 1'b1;
        move_ready = 1'b1;
        cycle();
        rst = 1'b0;
        move_ready = 1'b0;
        total++; if (move_valid !== 1'b0 || move !== 3'b000) $display("FAIL mid_valid got=%b/%b exp=0/000", move_valid, move); else pass_cnt++;
        total++; if (lane !== 3'b010) $display("FAIL mid_lane got=%b exp=010", lane); else pass_cnt++;
        total++; if (coins !== '0 || hits !== 4'd0 || lives !== 4'(T_LIVES)) $display("FAIL mid_counters got=%0d/%0d/%0d exp=0/0/%0d", coins, hits, lives, T_LIVES); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [1:0] r, c, l; logic [2:0] mv; bit ok; int lat; int idx;
        do_reset();
        model_reset();
        for (int n = 0; n < 150; n++) begin
            r = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            l = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) cycle();
            idx = model_pick(m_lane, r, c, l);
            send_row(r, c, l, int'($urandom_range(0, 3)), mv, ok, lat);
            model_score(idx, r, c, l);
            total++; if (mv !== hot(idx)) $display("FAIL rnd_move n=%0d got=%b exp=%b", n, mv, hot(idx)); else pass_cnt++;
            total++; if (lane !== hot(m_lane)) $display("FAIL rnd_lane n=%0d got=%b exp=%b", n, lane, hot(m_lane)); else pass_cnt++;
            total++; if (coins !== 2'(m_coins) || hits !== 4'(m_hits) || lives !== 4'(m_lives))
                $display("FAIL rnd_counters n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, coins, hits, lives, m_coins, m_hits, m_lives);
            else pass_cnt++;
            total++; if (game_over !== (m_lives == 0)) $display("FAIL rnd_game_over n=%0d got=%b exp=%b", n, game_over, (m_lives == 0)); else pass_cnt++;
            if (m_lives == 0) begin
                do_reset();
                model_reset();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        row_valid = 1'b0;
        move_ready = 1'b0;
        path_right = 2'b00; path_centre = 2'b00; path_left = 2'b00;
        test_reset();
        test_first_row();
        test_adjacency();
        test_backpressure();
        test_back_to_back();
        test_lives();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
